// File: rtl/mmu_drain.sv
// Drain side of the WTU block buffer: walks one full block in linear or
// bit-reversed order and streams it out over valid/ready with a last marker.
module mmu_drain #(
  parameter int BITWIDTH = 24,
  parameter int DEPTH    = 3,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                order_sel,
  input  logic                buf_ready,
  input  logic [BITWIDTH-1:0] buf_data,
  output logic [DEPTH-1:0]    buf_addr,
  output logic [BITWIDTH-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [DEPTH-1:0]    m_index,
  output logic                busy,
  output logic [CNTW-1:0]     blk_cnt
);

  localparam int WIDTH = 2 ** DEPTH;
  localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] idx;
  logic [DEPTH-1:0] idx_rev;
  logic [DEPTH-1:0] idx_ord;
  logic             ord_q;
  logic             at_last;
  logic             cap;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rev
    assign idx_rev[gi] = idx[DEPTH-1-gi];
  end

  assign idx_ord = ord_q ? idx_rev : idx;
  assign at_last = (idx == LAST_IDX);
  assign cap     = (state == DRAIN) && buf_ready && (!m_valid || m_ready);

  // The final address is only shown in the capture cycle; otherwise we park on
  // ord(0) (zero in either order), which has already been read, so the buffer
  // cannot release the block while the last sample is still unread.
  always_comb begin
    buf_addr = idx_ord;
    if (!rst) begin
      buf_addr = '0;
    end else if (state == DRAIN && at_last && !cap) begin
      buf_addr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= WAIT;
      idx     <= '0;
      ord_q   <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_index <= '0;
      blk_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      if (cap) begin
        m_data  <= buf_data;
        m_index <= idx_ord;
        m_valid <= 1'b1;
        m_last  <= at_last;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        WAIT: begin
          if (en && buf_ready) begin
            ord_q <= order_sel;
            idx   <= '0;
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          // Losing buf_ready mid-block is a protocol error: abandon the block
          // but let any held sample finish its handshake.
          if (!buf_ready) begin
            idx   <= '0;
            state <= WAIT;
            busy  <= 1'b0;
          end else if (cap) begin
            if (at_last) begin
              blk_cnt <= blk_cnt + CNTW'(1);
              idx     <= '0;
              state   <= GAP;
            end else begin
              idx <= idx + DEPTH'(1);
            end
          end
        end
        GAP: begin
          state <= WAIT;
          busy  <= 1'b0;
        end
        default: begin
          state <= WAIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_drain.sv
// Bench for mmu_drain: a behavioural block buffer that releases on reading its
// final address, plus an expected-sample list built from the read-order rules.
module tb_mmu_drain;

  localparam int BW = 24;
  localparam int DP = 3;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          order_sel = 1'b0;
  logic          m_ready = 1'b0;
  logic          buf_ready;
  logic [BW-1:0] buf_data;
  logic [DP-1:0] buf_addr;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [DP-1:0] m_index;
  logic          busy;
  logic [CW-1:0] blk_cnt;

  logic [BW-1:0] mem [W];
  int fills = 0;
  int rels = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_blk = 0;

  always #5 clk = ~clk;

  // Buffer model: full while fills outnumber releases; it releases the block
  // at any clock edge where its final address is being read.
  assign buf_ready = (fills != rels);
  assign buf_data  = mem[buf_addr];

  always @(posedge clk) begin
    if (!rst) rels <= fills;
    else if (buf_ready && buf_addr == DP'(W - 1)) rels <= rels + 1;
  end

  mmu_drain #(.BITWIDTH(BW), .DEPTH(DP), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .order_sel(order_sel),
    .buf_ready(buf_ready), .buf_data(buf_data), .buf_addr(buf_addr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_index(m_index), .busy(busy), .blk_cnt(blk_cnt)
  );

  function automatic logic [DP-1:0] rev(input logic [DP-1:0] a);
    logic [DP-1:0] r;
    for (int b = 0; b < DP; b++) r[b] = a[DP-1-b];
    return r;
  endfunction

  task automatic fill(input logic [BW-1:0] base);
    for (int i = 0; i < W; i++) mem[i] = base + BW'(i);
    fills = fills + 1;
  endtask

  // mode 0: m_ready always high; 1: five stall cycles while sample #6 is held;
  // 2: m_ready random 50%.
  task automatic drain_block(input logic [BW-1:0] base, input logic ord,
                             input int mode, input bit do_fill, input bit chk_lat);
    logic [BW-1:0] ed [W];
    logic [DP-1:0] ei [W];
    logic [BW-1:0] pd;
    logic [DP-1:0] pidx;
    logic          pl;
    bit            pv;
    bit            pr;
    int            k;
    int            t;
    int            stall;
    int            first;
    for (int i = 0; i < W; i++) begin
      ei[i] = ord ? rev(DP'(i)) : DP'(i);
      ed[i] = base + BW'(ei[i]);
    end
    pv = 0; pr = 0; pd = '0; pidx = '0; pl = 1'b0;
    k = 0; t = 0; stall = 0; first = -1;
    @(negedge clk);
    order_sel = ord;
    if (do_fill) fill(base);
    en = 1'b1;
    while (k < W && t < 200) begin
      @(negedge clk);
      order_sel = 1'($urandom_range(0, 1));
      case (mode)
        1: begin
          if (m_valid && k == 6 && stall < 5) begin
            m_ready = 1'b0;
            stall++;
          end else begin
            m_ready = 1'b1;
          end
        end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      #1;
      if (chk_lat && t == 0) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL start_busy got=%b exp=1", busy);
        end
      end
      if (pv && !pr) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_index !== pidx || m_last !== pl) begin
          n_fail++;
          $display("FAIL hold got v=%b d=%0d i=%0d l=%b exp v=1 d=%0d i=%0d l=%b",
                   m_valid, m_data, m_index, m_last, pd, pidx, pl);
        end
      end
      if (mode == 1 && !m_ready) begin
        n_checks++;
        if (buf_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_buf_ready got=%b exp=1", buf_ready);
        end
      end
      n_checks++;
      if (buf_ready && buf_addr === DP'(W - 1) &&
          ((k + (m_valid ? 1 : 0)) != W - 1 || (m_valid && !m_ready))) begin
        n_fail++;
        $display("FAIL addr_guard got buf_addr=%0d with %0d captured, v=%b r=%b exp not final addr",
                 buf_addr, k + (m_valid ? 1 : 0), m_valid, m_ready);
      end
      if (m_valid && first < 0) first = t;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== ed[k] || m_index !== ei[k] || m_last !== (k == W - 1)) begin
          n_fail++;
          $display("FAIL xfer k=%0d got d=%0d i=%0d l=%b exp d=%0d i=%0d l=%b",
                   k, m_data, m_index, m_last, ed[k], ei[k], (k == W - 1));
        end
        if (chk_lat && k == W - 1) begin
          n_checks++;
          if (t != W) begin
            n_fail++;
            $display("FAIL throughput last_at=%0d exp=%0d", t, W);
          end
        end
        k++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pidx = m_index; pl = m_last;
      t++;
    end
    n_checks++;
    if (k < W) begin
      n_fail++;
      $display("FAIL timeout got=%0d samples exp=%0d", k, W);
    end
    exp_blk++;
    if (chk_lat) begin
      n_checks++;
      if (first != 1) begin
        n_fail++;
        $display("FAIL latency got=%0d exp=1", first);
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || buf_ready !== 1'b0 || blk_cnt !== CW'(exp_blk)) begin
      n_fail++;
      $display("FAIL block_end got v=%b busy=%b bufrdy=%b cnt=%0d exp v=0 busy=0 bufrdy=0 cnt=%0d",
               m_valid, busy, buf_ready, blk_cnt, exp_blk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b l=%b busy=%b exp 0 0 0", m_valid, m_last, busy);
    end
    n_checks++;
    if (m_data !== '0 || m_index !== '0 || buf_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_data got d=%0d i=%0d a=%0d exp 0 0 0", m_data, m_index, buf_addr);
    end
    n_checks++;
    if (blk_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d exp=0", blk_cnt);
    end
    rst = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_linear();
    drain_block(BW'(10), 1'b0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_bitrev();
    drain_block(BW'(10), 1'b1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    drain_block(BW'(10), 1'b0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_en_gate();
    @(negedge clk);
    en = 1'b0;
    order_sel = 1'b0;
    fill(BW'(40));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || buf_addr !== '0) begin
        n_fail++;
        $display("FAIL en_gate got v=%b busy=%b a=%0d exp 0 0 0", m_valid, busy, buf_addr);
      end
    end
    drain_block(BW'(40), 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int k;
    int t;
    k = 0; t = 0;
    @(negedge clk);
    order_sel = 1'b0;
    m_ready = 1'b1;
    fill(BW'(70));
    while (k < 3 && t < 50) begin
      @(negedge clk);
      #1;
      if (m_valid && m_ready) k++;
      t++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (buf_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_addr got=%0d exp=0", buf_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || blk_cnt !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b cnt=%0d busy=%b exp 0 0 0", m_valid, blk_cnt, busy);
    end
    rst = 1'b1;
    exp_blk = 0;
    m_ready = 1'b0;
    drain_block(BW'(80), 1'b0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int start_blk;
    start_blk = exp_blk;
    for (int b = 0; b < 20; b++) begin
      drain_block(BW'(24'h100 + b * W), 1'($urandom_range(0, 1)), 2, 1'b1, 1'b0);
    end
    n_checks++;
    if (blk_cnt !== CW'(start_blk + 20)) begin
      n_fail++;
      $display("FAIL random_cnt got=%0d exp=%0d", blk_cnt, start_blk + 20);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_bitrev();
    test_backpressure();
    test_en_gate();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
